// File: rtl/jt12_pkg.sv
// Purpose: shared constants and helpers for the operator mix stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: none; the operator stream is free-running.
package jt12_pkg;

  // Default number of channels per slot group.
  localparam int NUM_CH_DEF = 6;

  // Channel accumulator width: 4 operators x 256 fits in 11 signed bits.
  localparam int RING_W = 11;

  // Frame accumulator width: 6 channels x 1024 fits in 14 signed bits.
  localparam int ACC_W = 14;

  // Operator identity; the encoding is the bit position in a carrier mask.
  typedef enum logic [1:0] {
    OP_S1 = 2'd0,
    OP_S2 = 2'd1,
    OP_S3 = 2'd2,
    OP_S4 = 2'd3
  } op_e;

  // Order in which the slot groups appear within a frame.
  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } slot_grp_e;

  // Per-algorithm carrier mask, bit0 = S1 .. bit3 = S4; index is alg.
  localparam logic [7:0][3:0] CARRIER_MASK = {
    4'b1111,  // alg 7: all four operators are carriers
    4'b1110,  // alg 6: S2, S3, S4
    4'b1110,  // alg 5: S2, S3, S4
    4'b1010,  // alg 4: S2, S4
    4'b1000,  // alg 3: S4 only
    4'b1000,  // alg 2: S4 only
    4'b1000,  // alg 1: S4 only
    4'b1000   // alg 0: S4 only
  };

  // Decoded slot: which operator owns the current cycle, if any.
  typedef struct packed {
    logic vld;
    op_e  op;
  } slot_t;

  // Resolve the slot flags with priority S1 > S3 > S2 > S4.
  function automatic slot_t decode_slot(input logic s1, input logic s2,
                                        input logic s3, input logic s4);
    slot_t r;
    r.vld = 1'b1;
    r.op  = OP_S1;
    if (s1)      r.op = OP_S1;
    else if (s3) r.op = OP_S3;
    else if (s2) r.op = OP_S2;
    else if (s4) r.op = OP_S4;
    else         r.vld = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/jt12_opmix_ring.sv
// Purpose: per-channel carrier accumulator ring, one stage per channel.
// Latency: a value written in slot t reappears at dout in slot t+NUM_CH.
// Backpressure: none; shifts every cycle.
module jt12_opmix_ring
  import jt12_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int W      = RING_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout
);

  logic signed [W-1:0] stage [NUM_CH];

  // Shift the ring one place per cycle; reset clears every channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < NUM_CH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[NUM_CH-1];

endmodule

// File: rtl/jt12_opmix.sv
// Purpose: select carrier operators, sum per channel, pan and emit one stereo sample per frame.
// Latency: slots up to the cycle before zero appear on left/right one cycle after zero.
// Backpressure: none; consumes one slot per cycle, sample is a single-cycle strobe.
module jt12_opmix
  import jt12_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int OUT_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [8:0]       op_result,
  input  logic                    s1_enters,
  input  logic                    s2_enters,
  input  logic                    s3_enters,
  input  logic                    s4_enters,
  input  logic                    zero,
  input  logic [2:0]              alg,
  input  logic [1:0]              rl,
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    sample
);

  localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (OUT_W - 1));

  // Clamp a frame accumulator into the output range.
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (int'(a) > SAT_MAX)      return OUT_W'(SAT_MAX);
    else if (int'(a) < SAT_MIN) return OUT_W'(SAT_MIN);
    else                        return OUT_W'(a);
  endfunction

  slot_t                    slot;
  logic                     carrier;
  logic                     is_s1;
  logic                     is_s4;
  logic signed [RING_W-1:0] carrier_term;
  logic signed [RING_W-1:0] ch_prev;
  logic signed [RING_W-1:0] ch_sum;
  logic signed [RING_W-1:0] ring_in;
  logic signed [ACC_W-1:0]  add_l;
  logic signed [ACC_W-1:0]  add_r;
  logic signed [ACC_W-1:0]  acc_l;
  logic signed [ACC_W-1:0]  acc_r;

  // Carrier selection, channel running sum and panned frame contribution.
  always_comb begin
    slot         = decode_slot(s1_enters, s2_enters, s3_enters, s4_enters);
    carrier      = slot.vld && CARRIER_MASK[alg][slot.op];
    is_s1        = slot.vld && (slot.op == OP_S1);
    is_s4        = slot.vld && (slot.op == OP_S4);
    carrier_term = carrier ? RING_W'(op_result) : '0;
    ch_sum       = ch_prev + carrier_term;
    // S1 opens a new channel total; any other slot extends it.
    ring_in      = is_s1 ? carrier_term : ch_sum;
    add_l        = (is_s4 && rl[1]) ? ACC_W'(ch_sum) : '0;
    add_r        = (is_s4 && rl[0]) ? ACC_W'(ch_sum) : '0;
  end

  jt12_opmix_ring #(
    .NUM_CH (NUM_CH),
    .W      (RING_W)
  ) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ring_in),
    .dout  (ch_prev)
  );

  // Frame accumulators and output registers; zero latches and reseeds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_l  <= '0;
      acc_r  <= '0;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
    end else begin
      sample <= zero;
      if (zero) begin
        // The zero slot's own contribution belongs to the next frame.
        left  <= sat(acc_l);
        right <= sat(acc_r);
        acc_l <= add_l;
        acc_r <= add_r;
      end else begin
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
      end
    end
  end

endmodule

// File: doc/jt12_opmix.md
# jt12_opmix

Receive end of the operator datapath. Takes the time-multiplexed signed operator output stream (24 slots per frame: 6 channels × 4 operators, group order S1, S3, S2, S4) and selects carrier operators per channel algorithm. It sums carriers into per-channel totals, pans each channel to left/right, and emits one saturated stereo sample per frame. Sits between the operator unit and the audio output/filter stage.

## Interface

Parameters:

- `NUM_CH`, 6: channels per slot group; depth of the channel accumulator ring.
- `OUT_W`, 12: signed width of `left`/`right`.

Ports:

- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `op_result` in 9: signed operator output for the current slot.
- `s1_enters`, `s2_enters`, `s3_enters`, `s4_enters` in 1 each: one-hot operator-slot flags, aligned with `op_result`.
- `zero` in 1: frame marker; high on slot 0 (ch0 S1).
- `alg` in 3: algorithm of the channel owning the current slot.
- `rl` in 2: pan of that channel; bit1 = left enable, bit0 = right enable.
- `left`, `right` out `OUT_W`: signed stereo sample.
- `sample` out 1: one-cycle strobe; `left`/`right` updated on this cycle.

## Operation

- Carrier rule (slot is carrier when):
  - S4: always.
  - S2: `alg` ≥ 4.
  - S3: `alg` ≥ 5.
  - S1: `alg` == 7.
- Carrier term = `op_result` sign-extended to 11 bits; 0 for non-carrier slots.
- Channel ring: `NUM_CH`-stage, 11-bit signed shift register advancing every cycle; its output `ch_prev` belongs to the current slot's channel.
  - Input = carrier term when `s1_enters`; otherwise `ch_prev` + carrier term.
  - Max magnitude is 4×256, so no overflow is possible.
- On `s4_enters`: `ch_sum` = `ch_prev` + carrier term.
  - Add `ch_sum` into the 14-bit signed `acc_l` if `rl[1]`, and into `acc_r` if `rl[0]`.
- On `zero`:
  - `left` ← sat(`acc_l`), `right` ← sat(`acc_r`).
  - `sample` ← 1.
  - `acc_l`/`acc_r` restart from this slot's contribution, or 0 if the slot is not S4.
- sat(): clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1], i.e. [−2048, 2047] at default.
- No slot flag high: no accumulation; the ring still advances, passing `ch_prev` through unchanged.
- More than one slot flag high: priority S1 > S3 > S2 > S4 for both the carrier decision and the clear/add decision.

## Timing

- Reset (`rst_n` low at an edge):
  - ring entries, `acc_l`, `acc_r`, `left`, `right` ← 0.
  - `sample` ← 0.
- Reset mid-frame discards the partial frame. The first `zero` after reset emits a sample built only from slots seen since reset.
- `sample` is registered: high exactly in the cycle after the `zero` cycle, low otherwise.
- `left`/`right` hold between strobes.
- Latency: the last slot of frame N (ch5 S4, cycle 23) is included in the sample registered on frame N+1's `zero` edge; visible 1 cycle after `zero`.
- `zero` and `s4_enters` in the same cycle (misaligned stream): the latched sample excludes that contribution; it seeds the next frame.
- `zero` spacing ≠ 24: a sample is emitted at each `zero` regardless. No error flag.
- Accumulators never wrap: 6 × 1024 < 2^13.

## Structure

- Shared package `jt12_pkg`:
  - algorithm carrier-mask constants (per-alg 4-bit S1..S4 mask);
  - slot-group order;
  - `NUM_CH` default.
- Sub-module `jt12_opmix_ring`: a `NUM_CH`-stage, 11-bit resettable shift register with synchronous active-low reset.
- Saturation is an inline function. The remaining logic is carrier select, two frame accumulators and output registers.

## Test plan

- Reset: hold `rst_n` low for 30 cycles with random stimulus -> `left`=`right`=0, `sample`=0 throughout; first `zero` after release gives `sample`=1 one cycle later.
- Alg 7, all channels, every slot `op_result`=+10, `rl`=2'b11 -> second frame's sample `left`=`right`=240 (6 ch × 4 ops × 10).
- Alg 0, S1..S3 = +100, S4 = −5, ch0 only (others 0), `rl`=2'b10 -> `left`=−5, `right`=0.
- Saturation: alg 7, all slots +255, `rl`=2'b11 -> raw sum 6120, `left`=`right`=2047; all slots −256 -> −2048.
- Alg 4 vs alg 3, ch2 only, S2=+50, S4=+20 -> alg 4 gives 70, alg 3 gives 20; ring clear at S1 proven by repeating over 3 frames with identical results.
- `zero` coincident with an S4 slot carrying +30 -> current sample excludes 30, next sample includes it; `rst_n` pulsed at slot 12 -> following sample contains only post-reset slots.
